// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcode encodings,
// fetch FSM state encoding and the default reset vector.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken-branch target or
// sequential PC, with jump taking priority over branch.
module next_pc_calc (
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] next_pc
);

   logic [31:0] w_br_off;
   logic [31:0] w_jump_tgt;
   logic        w_unused_opcode;

   // Branch offset is the sign-extended word displacement, shifted to bytes.
   assign w_br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign w_jump_tgt      = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign w_unused_opcode = ^instr[31:26];

   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = w_jump_tgt;
      else if (branch && zero)
         next_pc = pc_plus4 + w_br_off;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory request/ready
// handshake and valid/ready hand-off of the fetched word to decode.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_count
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic [31:0]  r_count;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_next_pc;
   logic         w_accept;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_accept   = (r_state == ST_HOLD) && instr_ready;

   next_pc_calc u_next_pc (
      .pc_plus4 (w_pc_plus4),
      .instr    (r_instr),
      .branch   (branch),
      .zero     (zero),
      .jump     (jump),
      .next_pc  (w_next_pc)
   );

   // Handshake outputs decode the state register only, so the async reset
   // drops them immediately and no input reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_count <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_accept) begin
                  r_pc    <= w_next_pc;
                  r_count <= r_count + 32'd1;
                  r_state <= ST_FETCH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = (r_state == ST_FETCH);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == ST_HOLD);
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr_count = r_count;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS core, directly upstream of the main control decoder. It holds the program counter and issues word reads to instruction memory over a request/ready handshake. It presents the fetched instruction and its opcode field to decode/execute over a valid/ready handshake. When an instruction is accepted, it updates the PC from the execute-side Branch/Zero/Jump outcome and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  byte address of the read; equals `pc`.
- `imem_ready`  in  1  instruction memory has data on `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction.
- `opcode`  out  6  `instr[31:26]`; drives the control decoder.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decode/execute accepts `instr` this cycle.
- `branch`, `jump`, `zero`  in  1 each  control/ALU outcome for the held instruction; sampled only on accept.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `instr_count`  out  32  number of accepted instructions; wraps.

## Operation
- States are IDLE, FETCH and HOLD.
- **IDLE** (reset state): `imem_req`=0. Always moves to FETCH on the next edge.
- **FETCH**:
  - `imem_req`=1 and `imem_addr`=`pc`; both stay stable until `imem_ready`.
  - When `imem_ready`=1: capture `imem_rdata` into `instr` and move to HOLD.
  - `imem_ready` is ignored in IDLE and HOLD.
- **HOLD**:
  - `instr_valid`=1 and `imem_req`=0; `instr` stays stable until accepted.
  - Accept = `instr_valid & instr_ready`. On accept: `pc` ← next PC, `instr_count` += 1, move to FETCH.
- Next PC, evaluated on accept, with `jump` taking priority over `branch`:
  - `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `branch & zero`: `pc_plus4 + (sign_extend(instr[15:0]) << 2)`, 32-bit modulo.
  - else: `pc_plus4`.
- Arithmetic wrap: `pc`=32'hFFFF_FFFC advances to 32'h0000_0000. `instr_count` wraps from 32'hFFFF_FFFF to 0. No flags are raised in either case.
- Reset mid-operation: `imem_req` and `instr_valid` drop immediately and asynchronously. Any in-flight memory response is discarded. After release, fetch restarts at `RESET_PC`.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0, `opcode`=0.
  - `instr_valid`=0, `imem_req`=0, `instr_count`=0.
  - `pc_plus4`=`RESET_PC`+4.
- First `imem_req` is asserted in the first cycle after the first rising edge following reset release.
- Zero-wait memory (`imem_ready` in the first FETCH cycle): `instr_valid` asserts the next cycle.
- k wait cycles: `instr_valid` asserts k+1 cycles after `imem_req` rises.
- Peak throughput is one instruction per 2 cycles (FETCH, HOLD).
- `instr_valid` and `imem_req` are never high in the same cycle.
- `opcode`, `pc` and `pc_plus4` are registered or derived from registers only. There is no combinational path from any input to them.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants: `OP_RTYPE`=000000, `OP_LW`=100011, `OP_SW`=101011, `OP_ADDI`=001000, `OP_BEQ`=000100, `OP_J`=000010.
  - Fetch state enum.
  - Default `RESET_PC`.
- One combinational sub-module, `next_pc_calc`:
  - Inputs: `pc_plus4`, `instr`, `branch`, `zero`, `jump`.
  - Output: next PC.
- The FSM, PC register, instruction register and counter live in `fetch_unit`.

## Test plan
- **Reset then zero-wait fetch:** release reset with `imem_ready` tied to 1 and `imem_rdata`=32'h8C08_0004 (lw) → `imem_addr`=0 in cycle 1, `instr_valid` in cycle 2, `opcode`=6'b100011.
- **Wait states:** `imem_ready` delayed 3 cycles → `imem_addr` stable for all 4 FETCH cycles; `instr_valid` asserts on the 5th cycle; `instr` captured exactly once.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles in HOLD → `instr`, `pc` and `instr_count` unchanged and `imem_req`=0 throughout; on accept, `pc` advances 0→4 and `instr_count` goes 0→1.
- **Branch:** `pc`=32'h0000_0010 with beq `instr`=32'h1000_FFFC, `branch`=1, `zero`=1 → next `pc`=32'h0000_0004. Same instruction with `zero`=0 → next `pc`=32'h0000_0014.
- **Jump priority and wrap:**
  - `jump`=1 and `branch`=1 with `instr[25:0]`=26'h0000100 at `pc`=32'h4000_0000 → next `pc`=32'h4000_0400.
  - Plain advance from `pc`=32'hFFFF_FFFC → `pc`=0.
- **Reset mid-fetch:** assert `rst_n`=0 while in FETCH with `imem_req`=1 → `imem_req` and `instr_valid` drop in the same cycle; after release, the first request is at `RESET_PC` and `instr_count`=0.
